// File: rtl/camellia_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the shared Camellia core.
// The arbiter takes the slave view; the requesters and the core together take the master view.
interface camellia_arbiter_if;
    logic         ch0_req;
    logic         ch1_req;
    logic         ch0_en_de;
    logic         ch1_en_de;
    logic [127:0] ch0_key;
    logic [127:0] ch1_key;
    logic [127:0] ch0_din;
    logic [127:0] ch1_din;
    logic         ch0_ack;
    logic         ch1_ack;
    logic         ch0_err;
    logic         ch1_err;
    logic [127:0] dout;
    logic         core_key_rdy;
    logic         core_data_rdy;
    logic         core_en_de;
    logic [127:0] core_key_in;
    logic [127:0] core_data_in;
    logic [127:0] core_data_out;
    logic         core_busy;
    logic         core_data_valid;

    modport slave (
        input  ch0_req, ch1_req, ch0_en_de, ch1_en_de, ch0_key, ch1_key, ch0_din, ch1_din,
        input  core_data_out, core_busy, core_data_valid,
        output ch0_ack, ch1_ack, ch0_err, ch1_err, dout,
        output core_key_rdy, core_data_rdy, core_en_de, core_key_in, core_data_in
    );

    modport master (
        output ch0_req, ch1_req, ch0_en_de, ch1_en_de, ch0_key, ch1_key, ch0_din, ch1_din,
        output core_data_out, core_busy, core_data_valid,
        input  ch0_ack, ch1_ack, ch0_err, ch1_err, dout,
        input  core_key_rdy, core_data_rdy, core_en_de, core_key_in, core_data_in
    );
endinterface

// File: rtl/camellia_arbiter.sv
// Round-robin sequencer sharing one Camellia core between two requesters, with a
// single-entry key cache that skips the key schedule when the granted key is already loaded.
module camellia_arbiter #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CW      = 7
) (
    input logic               clk,
    input logic               rst,
    camellia_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StKeyGo,
        StKeyWait,
        StDataGo,
        StDataWait,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [127:0]   job_key_q, job_key_d;
    logic [127:0]   job_din_q, job_din_d;
    logic           job_mode_q, job_mode_d;
    logic           owner_q, owner_d;
    logic           last_grant_q, last_grant_d;
    logic [127:0]   cached_key_q, cached_key_d;
    logic           key_valid_q, key_valid_d;
    logic [CW-1:0]  wdog_q, wdog_d;
    logic [127:0]   dout_q, dout_d;
    logic           ack0_q, ack0_d, ack1_q, ack1_d;
    logic           err0_q, err0_d, err1_q, err1_d;
    logic           key_rdy_q, key_rdy_d;
    logic           data_rdy_q, data_rdy_d;

    logic           grant;
    logic [CW-1:0]  wdog_inc;
    logic           timeout;

    // On a tie the channel that did not win last time is served.
    assign grant    = (bus.ch0_req && bus.ch1_req) ? ~last_grant_q : bus.ch1_req;
    assign wdog_inc = wdog_q + CW'(1);
    assign timeout  = (wdog_inc == CW'(TIMEOUT));

    always_comb begin
        state_d      = state_q;
        job_key_d    = job_key_q;
        job_din_d    = job_din_q;
        job_mode_d   = job_mode_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cached_key_d = cached_key_q;
        key_valid_d  = key_valid_q;
        wdog_d       = wdog_q;
        dout_d       = dout_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        key_rdy_d    = 1'b0;
        data_rdy_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.ch0_req || bus.ch1_req) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    job_key_d    = grant ? bus.ch1_key : bus.ch0_key;
                    job_din_d    = grant ? bus.ch1_din : bus.ch0_din;
                    job_mode_d   = grant ? bus.ch1_en_de : bus.ch0_en_de;
                    if (key_valid_q && (job_key_d == cached_key_q)) begin
                        state_d    = StDataGo;
                        data_rdy_d = 1'b1;
                    end else begin
                        state_d   = StKeyGo;
                        key_rdy_d = 1'b1;
                    end
                end
            end
            StKeyGo: begin
                key_valid_d = 1'b0;
                wdog_d      = '0;
                state_d     = StKeyWait;
            end
            StKeyWait: begin
                wdog_d = wdog_inc;
                if (!bus.core_busy) begin
                    cached_key_d = job_key_q;
                    key_valid_d  = 1'b1;
                    state_d      = StDataGo;
                    data_rdy_d   = 1'b1;
                end else if (timeout) begin
                    err0_d      = ~owner_q;
                    err1_d      = owner_q;
                    key_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            StDataGo: begin
                wdog_d  = '0;
                state_d = StDataWait;
            end
            StDataWait: begin
                wdog_d = wdog_inc;
                if (bus.core_data_valid) begin
                    dout_d  = bus.core_data_out;
                    state_d = StDone;
                end else if (timeout) begin
                    // The core may be wedged mid-schedule, so the cached key is no longer trusted.
                    err0_d      = ~owner_q;
                    err1_d      = owner_q;
                    key_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            StDone: begin
                ack0_d  = ~owner_q;
                ack1_d  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            job_key_q    <= '0;
            job_din_q    <= '0;
            job_mode_q   <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cached_key_q <= '0;
            key_valid_q  <= 1'b0;
            wdog_q       <= '0;
            dout_q       <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            key_rdy_q    <= 1'b0;
            data_rdy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            job_key_q    <= job_key_d;
            job_din_q    <= job_din_d;
            job_mode_q   <= job_mode_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cached_key_q <= cached_key_d;
            key_valid_q  <= key_valid_d;
            wdog_q       <= wdog_d;
            dout_q       <= dout_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            key_rdy_q    <= key_rdy_d;
            data_rdy_q   <= data_rdy_d;
        end
    end

    assign bus.ch0_ack       = ack0_q;
    assign bus.ch1_ack       = ack1_q;
    assign bus.ch0_err       = err0_q;
    assign bus.ch1_err       = err1_q;
    assign bus.dout          = dout_q;
    assign bus.core_key_rdy  = key_rdy_q;
    assign bus.core_data_rdy = data_rdy_q;
    assign bus.core_en_de    = job_mode_q;
    assign bus.core_key_in   = job_key_q;
    assign bus.core_data_in  = job_din_q;

endmodule

// File: doc/camellia_arbiter.md
# camellia_arbiter

Sequencer that shares one Camellia encryption/decryption core (`top`: key_rdy/data_rdy strobes, busy, data_valid) between two requesters. It arbitrates round-robin and issues the key-load and data strobes in the order the core requires. It skips the key schedule when the granted key matches the key already loaded, and returns each result, or a timeout error, to the owning requester. It sits between the host-side request logic and the core.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum cycles spent in KEY_WAIT or DATA_WAIT before aborting.
- `CW`, 7: width of the watchdog counter; must satisfy 2^CW > TIMEOUT.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ch0_req`, `ch1_req`  in  1  job request, level; held high until the matching ack or err.
- `ch0_en_de`, `ch1_en_de`  in  1  0 = encrypt, 1 = decrypt.
- `ch0_key`, `ch1_key`  in  128  key, sampled at grant.
- `ch0_din`, `ch1_din`  in  128  input block, sampled at grant.
- `ch0_ack`, `ch1_ack`  out  1  one-cycle pulse; result valid on `dout`.
- `ch0_err`, `ch1_err`  out  1  one-cycle pulse; job aborted by timeout.
- `dout`  out  128  result of the acked job, held until the next ack.
- `core_key_rdy`, `core_data_rdy`  out  1  one-cycle strobes to the core.
- `core_en_de`  out  1  mode to the core.
- `core_key_in`, `core_data_in`  out  128  operands to the core.
- `core_data_out`  in  128  core result.
- `core_busy`, `core_data_valid`  in  1  core status. The core raises busy in the cycle after either strobe. data_valid pulses with the result.

## Operation
- Registers: `job_key`, `job_din`, `job_mode`, `owner` (1 bit), `last_grant`, `cached_key` (128), `key_valid`, `wdog` (CW bits).
- States: IDLE, KEY_GO, KEY_WAIT, DATA_GO, DATA_WAIT, DONE.
- IDLE: when any request is high, grant it. If both are high, grant the channel ≠ `last_grant`. Latch the operands and `owner`, and set `last_grant` = owner.
  - If `key_valid` and `job_key == cached_key`, go to DATA_GO.
  - Otherwise go to KEY_GO.
- KEY_GO: `core_key_rdy` = 1 for one cycle. Clear `key_valid`, clear `wdog`, then go to KEY_WAIT.
- KEY_WAIT: wait at least one cycle. On `core_busy == 0`, set `cached_key` = `job_key` and `key_valid` = 1, then go to DATA_GO.
- DATA_GO: `core_data_rdy` = 1 for one cycle, with `core_en_de` = `job_mode`. Clear `wdog`, then go to DATA_WAIT.
- DATA_WAIT: on `core_data_valid`, capture `core_data_out` into `dout` and go to DONE.
- DONE: pulse `chN_ack` for the owner, then go to IDLE. The requester drops req; a req still high in the following IDLE cycle counts as a new job.
- Timeout: `wdog` increments each cycle in KEY_WAIT and DATA_WAIT. When `wdog == TIMEOUT`, pulse `chN_err` for the owner, clear `key_valid`, and go to IDLE. `dout` is unchanged.
- `core_key_in` and `core_data_in` drive `job_key` and `job_din` continuously. `core_en_de` drives `job_mode`.
- Reset: state IDLE, `key_valid` = 0, `last_grant` = 1 (channel 0 wins the first tie). All ack, err and strobe outputs are 0; `dout` = 0; `wdog` = 0.
- Reset mid-job: the job is abandoned with no ack or err. The core is not otherwise reset, and the key cache is invalid afterwards.
- A request withdrawn before grant is ignored. A request withdrawn after grant still runs to completion.
- `core_data_valid` outside DATA_WAIT is ignored.

## Timing
- Grant: cycle 0 (IDLE sees req).
- Key-load path: KEY_GO at cycle 1. KEY_WAIT starts at cycle 2 and lasts ≥1 cycle. `core_data_rdy` follows at (cycle KEY_WAIT exits) + 1.
- Cached-key path: `core_data_rdy` at cycle 1.
- Ack: asserted 2 cycles after `core_data_valid` (capture in DATA_WAIT, pulse in DONE).
- Back-to-back: the next grant happens at the earliest in the cycle after DONE. The arbitration overhead is 2 cycles per job plus the optional key schedule.
- At most one of `ch0_ack`, `ch1_ack`, `ch0_err`, `ch1_err` is high in any cycle.

## Test plan
- Encrypt, cold cache: ch0 key = data = 0123456789abcdeffedcba9876543210, en_de = 0.
  - Exactly one `core_key_rdy`, then one `core_data_rdy`.
  - `ch0_ack` with `dout` = 67673138549669730857065648eabe43.
- Repeat the same job on ch0: no `core_key_rdy`, `core_data_rdy` 1 cycle after grant, same `dout`.
- ch1 decrypts 67673138549669730857065648eabe43 with the same key and en_de = 1: no key reload; `ch1_ack` with `dout` = 0123456789abcdeffedcba9876543210.
- ch0 and ch1 raise req in the same cycle after reset with different keys: ch0 is served first and ch1 second. Each key is loaded, giving 2 `core_key_rdy` pulses total, and each ack carries the correct result.
- Core model never asserts `core_data_valid`: `ch0_err` pulses exactly TIMEOUT + 1 cycles after `core_data_rdy`. The next job with the same key reloads the key.
- `rst` asserted during DATA_WAIT: the next cycle shows state IDLE, all outputs 0, and no ack. The next job issues `core_key_rdy`.
